// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared word type, arbiter states and request-latch layout for the memory responder.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage

package mem_resp_pkg;
  import rv32i_types::*;
  localparam int LAT_W = 4;
  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B, GAP} state_e;
  typedef struct packed {
    logic port;
    logic is_write;
    logic [29:0] index;
    logic [3:0] wmask;
    rv32i_word wdata;
  } req_t;
endpackage

// File: rtl/masked_sram.sv
// masked_sram: single-port word array, byte-masked synchronous write, registered read.
module masked_sram #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [3:0]        i_wmask,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);
  logic [31:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (i_we && i_wmask[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/dual_port_mem_responder.sv
// dual_port_mem_responder: arbitrates CPU instruction (A) and data (B) ports onto one array
// with a fixed grant-to-response latency and a one-cycle gap after every response.
module dual_port_mem_responder
  import rv32i_types::*;
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  output logic        resp_b,
  output logic [31:0] rdata_b,
  output logic        proto_err
);
  state_e r_state, w_next;
  req_t r_req;
  logic [LAT_W-1:0] r_cnt;
  logic r_proto_err;
  rv32i_word r_rdata_a, r_rdata_b, w_q, w_addr_in;
  logic w_req_b, w_grant, w_we;
  logic [ADDR_W-1:0] w_idx;
  assign w_req_b = read_b | write;
  assign w_grant = (r_state == IDLE) && (w_req_b || read_a);
  assign w_we = (r_state == IDLE) && write;
  assign w_addr_in = w_req_b ? address_b : address_a;
  // In IDLE the array sees the incoming address so a LATENCY=1 read is sampled at grant.
  assign w_idx = (r_state == IDLE) ? w_addr_in[ADDR_W+1:2] : r_req.index[ADDR_W-1:0];
  masked_sram #(.ADDR_W(ADDR_W)) u_sram (
    .clk(clk), .i_we(w_we), .i_wmask(wmask), .i_addr(w_idx), .i_wdata(wdata), .o_rdata(w_q)
  );
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb
    w_next = (r_state == IDLE) ? (w_req_b ? BUSY_B : read_a ? BUSY_A : IDLE) :
             (r_state == GAP) ? IDLE : (r_cnt == '0) ? GAP : r_state;
  always_comb begin
    resp_a = (r_state == BUSY_A) && (r_cnt == '0);
    resp_b = (r_state == BUSY_B) && (r_cnt == '0);
    rdata_a = resp_a ? w_q : r_rdata_a;
    rdata_b = (resp_b && !r_req.is_write) ? w_q : r_rdata_b;
    proto_err = r_proto_err;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_req <= '0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_cnt <= LAT_W'(LATENCY - 1);
        r_req <= '{port: w_req_b, is_write: write, index: w_addr_in[31:2], wmask: wmask, wdata: wdata};
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (resp_a) r_rdata_a <= w_q;
      if (resp_b && !r_req.is_write) r_rdata_b <= w_q;
      if (w_grant && read_b && write) r_proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dual_port_mem_responder.sv
// tb_dual_port_mem_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_dual_port_mem_responder;
  localparam int ADDR_W = 16;
  localparam int LATENCY = 3;
  localparam int DEPTH = 2**ADDR_W;
  logic clk = 0, reset = 1;
  logic read_a = 0, read_b = 0, write = 0;
  logic [31:0] address_a = 0, address_b = 0, wdata = 0;
  logic [3:0] wmask = 0;
  logic resp_a, resp_b, proto_err;
  logic [31:0] rdata_a, rdata_b;
  int checks = 0, failures = 0;
  logic [31:0] model [int];
  logic [31:0] last_a = 0, last_b = 0;
  logic [31:0] pool [8];

  dual_port_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .read_a(read_a), .address_a(address_a), .resp_a(resp_a),
    .rdata_a(rdata_a), .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b),
    .wdata(wdata), .resp_b(resp_b), .rdata_b(rdata_b), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (!reset) chk("one_resp", 32'(resp_a & resp_b), 0);

  function automatic int idx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = model.exists(idx(a)) ? model[idx(a)] : 32'h0;
    for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
    model[idx(a)] = w;
  endtask

  task automatic wait_resp(input logic want_b, output int n, output logic [31:0] d);
    n = 0;
    d = 0;
    forever begin
      @(negedge clk);
      if (want_b ? resp_b : resp_a) begin
        d = want_b ? rdata_b : rdata_a;
        return;
      end
      n++;
      if (n > 40) begin
        chk("resp_timeout", 32'(n), 32'(LATENCY));
        return;
      end
    end
  endtask

  task automatic drop;
    @(posedge clk); #1;
    read_a = 0; read_b = 0; write = 0;
  endtask

  // kind 0: read_a, 1: read_b, 2: write
  task automatic op(input int kind, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int n;
    logic [31:0] got;
    @(posedge clk); #1;
    read_a = (kind == 0); read_b = (kind == 1); write = (kind == 2);
    address_a = a; address_b = a; wdata = d; wmask = m;
    if (kind == 2) model_write(a, d, m);
    wait_resp(kind != 0, n, got);
    chk("latency", 32'(n), 32'(LATENCY));
    if (kind == 0) begin
      chk("rdata_a", got, model[idx(a)]);
      last_a = model[idx(a)];
    end else if (kind == 1) begin
      chk("rdata_b", got, model[idx(a)]);
      last_b = model[idx(a)];
    end else begin
      chk("rdata_b_hold_on_write", got, last_b);
      chk("rdata_a_hold", rdata_a, last_a);
    end
    drop();
  endtask

  initial begin
    int n;
    logic [31:0] got, a, d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_a", 32'(resp_a), 0);
    chk("rst_resp_b", 32'(resp_b), 0);
    chk("rst_rdata_a", rdata_a, 0);
    chk("rst_rdata_b", rdata_b, 0);
    chk("rst_proto", 32'(proto_err), 0);
    @(posedge clk); #1 reset = 0;

    op(2, 32'h40, 32'hDEADBEEF, 4'hF);
    @(posedge clk); #1;
    read_a = 1; address_a = 32'h40;
    wait_resp(0, n, got);
    chk("held_a_lat", 32'(n), 32'(LATENCY));
    chk("held_a_data", got, 32'hDEADBEEF);
    wait_resp(0, n, got);
    chk("held_a_spacing", 32'(n), 32'(LATENCY + 1));
    chk("held_a_data2", got, 32'hDEADBEEF);
    last_a = 32'hDEADBEEF;
    drop();

    @(posedge clk); #1;
    read_a = 1; address_a = 32'h40;
    write = 1; address_b = 32'h80; wdata = 32'h11223344; wmask = 4'hF;
    model_write(32'h80, 32'h11223344, 4'hF);
    wait_resp(1, n, got);
    chk("prio_b_lat", 32'(n), 32'(LATENCY));
    @(posedge clk); #1 write = 0;
    wait_resp(0, n, got);
    chk("prio_a_after_gap", 32'(n), 32'(LATENCY + 1));
    chk("prio_a_data", got, 32'hDEADBEEF);
    drop();
    op(1, 32'h80, 0, 0);

    op(2, 32'h100, 32'hAABBCCDD, 4'hF);
    op(2, 32'h100, 32'h11223344, 4'b0101);
    op(1, 32'h100, 0, 0);
    chk("mask_literal", last_b, 32'hAA22CC44);
    op(2, 32'h104, 32'h55667788, 4'b0000);
    op(1, 32'h104, 0, 0);

    op(2, 32'h0004_0008, 32'hCAFEF00D, 4'hF);
    op(0, 32'h8, 0, 0);
    chk("alias_literal", last_a, 32'hCAFEF00D);

    chk("proto_before", 32'(proto_err), 0);
    @(posedge clk); #1;
    read_b = 1; write = 1; address_b = 32'h200; wdata = 32'h0BADC0DE; wmask = 4'hF;
    model_write(32'h200, 32'h0BADC0DE, 4'hF);
    wait_resp(1, n, got);
    chk("proto_lat", 32'(n), 32'(LATENCY));
    chk("proto_no_rdata", got, last_b);
    chk("proto_set", 32'(proto_err), 1);
    drop();
    op(0, 32'h200, 0, 0);
    chk("proto_sticky", 32'(proto_err), 1);

    @(posedge clk); #1;
    read_b = 1; address_b = 32'h40;
    repeat (LATENCY - 1) @(negedge clk);
    @(posedge clk); #1;
    reset = 1; read_b = 0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_resp_b", 32'(resp_b), 0);
    chk("abort_resp_a", 32'(resp_a), 0);
    chk("abort_rdata_a", rdata_a, 0);
    chk("abort_rdata_b", rdata_b, 0);
    chk("abort_proto", 32'(proto_err), 0);
    @(posedge clk); #1 reset = 0;
    last_a = 0; last_b = 0;
    op(1, 32'h40, 0, 0);

    for (int i = 0; i < 8; i++) begin
      pool[i] = $urandom;
      op(2, pool[i], $urandom, 4'hF);
    end
    for (int i = 0; i < 40; i++) begin
      a = pool[$urandom_range(0, 7)];
      d = $urandom;
      a[31:ADDR_W+2] = d[31:ADDR_W+2];
      a[1:0] = d[1:0];
      op($urandom_range(0, 2), a, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dual_port_mem_responder.md
Name: dual_port_mem_responder

Overview:
- Responder (memory side) for the CPU's two memory ports: port A is instruction read-only; port B is data read/write with byte mask.
- Serves both ports from one single-ported word-addressed backing array. Arbitrates between ports, applies a programmable fixed access latency, and returns one-cycle resp pulses with read data.
- Sits below the cpu top as the simulation/FPGA memory model, in place of the caches.

Parameters:
- ADDR_W, 16, word-index width; array depth = 2**ADDR_W words of 32 bits.
- LATENCY, 3, cycles from grant to resp; legal range 1..15.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- read_a  input  1  port A read request, held until resp_a.
- address_a  input  32  port A byte address.
- resp_a  output  1  one-cycle completion pulse, port A.
- rdata_a  output  32  port A read data, valid while resp_a=1.
- read_b  input  1  port B read request, held until resp_b.
- write  input  1  port B write request, held until resp_b.
- wmask  input  4  port B byte enables; bit i enables byte lane [8i+7:8i].
- address_b  input  32  port B byte address.
- wdata  input  32  port B write data.
- resp_b  output  1  one-cycle completion pulse, port B.
- rdata_b  output  32  port B read data, valid while resp_b=1 for a read.
- proto_err  output  1  sticky flag: read_b and write were both high on a port B grant.

Behaviour:
- Reset values: resp_a=0, resp_b=0, rdata_a=0, rdata_b=0, proto_err=0, state=IDLE, counter=0. Array contents are not reset.
- Index = address[ADDR_W+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so addresses wrap modulo the array depth.
- FSM states: IDLE, BUSY_A, BUSY_B, GAP.
- IDLE, grant rules:
  - A port B request (read_b|write) is granted first.
  - Otherwise a read_a request is granted.
  - Otherwise stay in IDLE.
- Grant in cycle t:
  - Latch port, index, op, wmask and wdata at the end of cycle t.
  - Load the counter with LATENCY-1.
  - Go to BUSY_x.
- Writes commit to the array at the end of the grant cycle; wmask=0000 commits nothing but still responds.
- Reads sample the array at the end of the cycle before resp.
- BUSY_x: decrement the counter. When the counter is 0, assert resp_x and rdata_x in that cycle (cycle t+LATENCY), then go to GAP.
- GAP: lasts one cycle; no grant is made. This lets the requester drop or change its request after seeing resp. Then go to IDLE.
- Throughput: one access per LATENCY+2 cycles.
- rdata_x holds its last returned value outside resp cycles. rdata_b is unchanged on write completion.
- Only one resp is high in any cycle; resp_a and resp_b are never simultaneous.
- Protocol violations:
  - read_b and write both high at grant: treat as write and set proto_err until reset.
  - A request dropped during BUSY: the access still completes and resp still pulses.
- Reset mid-access: abandon immediately; no resp is issued. A write already committed at grant stays committed.
- Port A starvation is acceptable: the CPU's fetch stalls while port B is busy.

Decomposition:
- Shared package mem_resp_pkg imports rv32i_types (rv32i_word) and holds:
  - the state enum (IDLE, BUSY_A, BUSY_B, GAP);
  - the request-latch struct {port, is_write, index, wmask, wdata};
  - the constant LAT_W=4.
- One sub-module, masked_sram: single-port, synchronous write with 4-bit byte mask, registered read, parameter ADDR_W.
- The arbiter FSM, latency counter and resp/rdata registers live in the top.

Test Plan:
- Reset, then preload word 0x10 = 0xDEADBEEF. Hold read_a, address_a=0x40, LATENCY=3, first visible in cycle 0 -> resp_a=1 only in cycle 3 with rdata_a=0xDEADBEEF. Then GAP in cycle 4; next grant no earlier than cycle 5.
- read_a and write asserted in the same cycle (address_b=0x80, wdata=0x11223344, wmask=1111) -> port B is served first and resp_b pulses. Port A is granted after GAP; resp_a arrives LATENCY+2 cycles after resp_b.
- Word holds 0xAABBCCDD. Write wmask=0101, wdata=0x11223344 to it, then read_b the same address -> rdata_b=0xAA22CC44.
- address_b=0x0004_0008 with ADDR_W=16 -> aliases to index 2. A write there, followed by read_a of 0x8, returns the written word.
- read_b=1 and write=1 at grant -> the access behaves as a write and proto_err=1 stays high until reset.
- Assert reset in the cycle before resp_b is due -> no resp_b pulse, all outputs 0 the next cycle, and a new request is granted normally afterwards.
